// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: widths, memory ops, FSM states, byte enables.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_stage_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 32;
    localparam int RADDR_WIDTH = 5;

    // Memory operation codes, shared with the execute stage.
    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LH   = 4'd2,
        MEM_OP_LW   = 4'd3,
        MEM_OP_LBU  = 4'd4,
        MEM_OP_LHU  = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // Codes outside LB..SW are treated as plain ALU results.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and misalignment detection.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]            op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic                  misalign,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign bus_addr  = {addr[ADDR_WIDTH-1:2], 2'b00};
    assign lane_byte = load_word[{addr[1:0], 3'b000} +: 8];
    assign lane_half = addr[1] ? load_word[31:16] : load_word[15:0];

    // Decode the op into lane enables, replicated store data, extended load data and alignment.
    always_comb begin
        misalign  = 1'b0;
        bus_be    = BE_NONE;
        bus_wdata = store_data;
        load_data = '0;
        case (op)
            MEM_OP_LB: begin
                bus_be    = BE_ALL;
                load_data = {{24{lane_byte[7]}}, lane_byte};
            end
            MEM_OP_LBU: begin
                bus_be    = BE_ALL;
                load_data = {24'd0, lane_byte};
            end
            MEM_OP_LH: begin
                bus_be    = BE_ALL;
                misalign  = addr[0];
                load_data = {{16{lane_half[15]}}, lane_half};
            end
            MEM_OP_LHU: begin
                bus_be    = BE_ALL;
                misalign  = addr[0];
                load_data = {16'd0, lane_half};
            end
            MEM_OP_LW: begin
                bus_be    = BE_ALL;
                misalign  = (addr[1:0] != 2'b00);
                load_data = load_word;
            end
            MEM_OP_SB: begin
                bus_be    = BE_B0 << addr[1:0];
                bus_wdata = {4{store_data[7:0]}};
            end
            MEM_OP_SH: begin
                bus_be    = addr[1] ? BE_HI : BE_LO;
                misalign  = addr[0];
                bus_wdata = {2{store_data[15:0]}};
            end
            MEM_OP_SW: begin
                bus_be    = BE_ALL;
                misalign  = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results and runs req/ack data-bus transactions for loads/stores.
// Latency: 1 cycle for non-memory and misaligned ops; 1 + bus cycles (min 2) for loads/stores.
// Backpressure: stall_o holds upstream while an access is pending; it drops in the ack/timeout cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   valid_i,
    input  logic                   mem_we_i,
    input  logic [3:0]             mem_op_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic                   reg_we_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    output logic                   stall_o,
    output logic                   valid_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [ADDR_WIDTH-1:0]  dbus_addr_o,
    output logic [3:0]             dbus_be_o,
    output logic [DATA_WIDTH-1:0]  dbus_wdata_o,
    input  logic [DATA_WIDTH-1:0]  dbus_rdata_i,
    input  logic                   dbus_ack_i,
    output logic                   misalign_o,
    output logic                   bus_err_o
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_nxt;
    logic [7:0]             tmo_cnt;
    logic [3:0]             op_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  sdata_q;
    logic                   we_q;
    logic                   rwe_q;
    logic [RADDR_WIDTH-1:0] rwaddr_q;

    logic                   busy;
    logic                   tmo_hit;
    logic                   live_mem;
    logic [3:0]             acc_op;
    logic [ADDR_WIDTH-1:0]  acc_addr;
    logic [DATA_WIDTH-1:0]  acc_sdata;
    logic                   misalign;
    logic [ADDR_WIDTH-1:0]  bus_addr;
    logic [3:0]             bus_be;
    logic [DATA_WIDTH-1:0]  bus_wdata;
    logic [DATA_WIDTH-1:0]  load_data;

    assign busy     = (state == ST_BUS);
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign live_mem = is_mem_op(mem_op_i);

    // One aligner serves both the alignment check on live inputs and steering of the held access.
    assign acc_op    = busy ? op_q    : mem_op_i;
    assign acc_addr  = busy ? addr_q  : mem_addr_i;
    assign acc_sdata = busy ? sdata_q : mem_data_i;

    mem_align u_align (
        .op         (acc_op),
        .addr       (acc_addr),
        .store_data (acc_sdata),
        .load_word  (dbus_rdata_i),
        .misalign   (misalign),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .load_data  (load_data)
    );

    // Bus fields are only driven while a transaction is open, so they read zero when idle.
    assign dbus_we_o    = busy & we_q;
    assign dbus_addr_o  = busy ? bus_addr  : '0;
    assign dbus_be_o    = busy ? bus_be    : BE_NONE;
    assign dbus_wdata_o = busy ? bus_wdata : '0;

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state, request and stall; ack takes priority over the timeout in the same cycle.
    always_comb begin
        state_nxt  = state;
        stall_o    = 1'b0;
        dbus_req_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid_i && live_mem && !misalign) begin
                    state_nxt = ST_BUS;
                    stall_o   = 1'b1;
                end
            end
            ST_BUS: begin
                dbus_req_o = 1'b1;
                if (dbus_ack_i || tmo_hit) state_nxt = ST_IDLE;
                else                       stall_o   = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Access latch, timeout counter and registered writeback/pulse outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tmo_cnt     <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            sdata_q     <= '0;
            we_q        <= 1'b0;
            rwe_q       <= 1'b0;
            rwaddr_q    <= '0;
            valid_o     <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= '0;
            misalign_o  <= 1'b0;
            bus_err_o   <= 1'b0;
        end else begin
            valid_o    <= 1'b0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i && !live_mem) begin
                        valid_o     <= 1'b1;
                        reg_we_o    <= reg_we_i;
                        reg_waddr_o <= reg_waddr_i;
                        reg_wdata_o <= reg_wdata_i;
                    end else if (valid_i && misalign) begin
                        valid_o     <= 1'b1;
                        reg_we_o    <= 1'b0;
                        reg_waddr_o <= reg_waddr_i;
                        reg_wdata_o <= '0;
                        misalign_o  <= 1'b1;
                    end else if (valid_i) begin
                        op_q     <= mem_op_i;
                        addr_q   <= mem_addr_i;
                        sdata_q  <= mem_data_i;
                        we_q     <= mem_we_i;
                        rwe_q    <= reg_we_i;
                        rwaddr_q <= reg_waddr_i;
                        tmo_cnt  <= '0;
                    end
                end
                ST_BUS: begin
                    if (dbus_ack_i) begin
                        valid_o     <= 1'b1;
                        reg_we_o    <= rwe_q & ~we_q;
                        reg_waddr_o <= rwaddr_q;
                        reg_wdata_o <= we_q ? '0 : load_data;
                        tmo_cnt     <= '0;
                    end else if (tmo_hit) begin
                        valid_o     <= 1'b1;
                        reg_we_o    <= 1'b0;
                        reg_waddr_o <= rwaddr_q;
                        reg_wdata_o <= '0;
                        bus_err_o   <= 1'b1;
                        tmo_cnt     <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
